// File: rtl/sdr_pkg.sv
// sdr_pkg: shared constants, types and the quarter-sine table generator for the
// four-lane digital down-converter (sdr_core / nco_lut).
//   - Width constants for ADC samples, NCO amplitude, products and lane count.
//   - Default frequency tuning word (200 MHz at 1 GSPS).
//   - sample_t: one signed ADC sample; iq_t: one full-precision I/Q product pair.
//   - quarter_sine(): entry i of the (qn+1)-entry quarter-wave sine table,
//     evaluated at elaboration to fill the LUT ROM.
package sdr_pkg;

  localparam int SDR_ADC_W  = 12;
  localparam int SDR_NCO_W  = 16;
  localparam int SDR_PROD_W = SDR_ADC_W + SDR_NCO_W;
  localparam int SDR_LANES  = 4;

  // 0.2 * 2^32: 200 MHz tone at 1 GSPS input sample rate
  localparam logic [31:0] SDR_FTW_DEFAULT = 32'd858993459;

  localparam real SDR_PI = 3.14159265358979323846;

  typedef logic signed [SDR_ADC_W-1:0] sample_t;

  typedef struct packed {
    logic signed [SDR_PROD_W-1:0] i;
    logic signed [SDR_PROD_W-1:0] q;
  } iq_t;

  // round(amp * sin(pi/2 * idx / qn)); all arguments are non-negative, so
  // adding 0.5 before truncation rounds to nearest. idx = qn gives exactly amp.
  function automatic int quarter_sine(input int idx, input int qn, input int amp);
    real ang;
    ang = SDR_PI / 2.0 * real'(idx) / real'(qn);
    return $rtoi(real'(amp) * $sin(ang) + 0.5);
  endfunction

endpackage

// File: rtl/nco_lut.sv
// nco_lut: phase-to-cos/sin lookup with quarter-wave symmetry and a registered
// output (one cycle of latency).
//   clk    : clock
//   rst_n  : asynchronous active-low reset, clears cos_o/sin_o to 0
//   phase  : LUT_AW-bit phase, full turn = 2^LUT_AW
//   cos_o  : registered signed cosine, full scale +/-(2^(NCO_W-1)-1)
//   sin_o  : registered signed sine, same scale
module nco_lut
  import sdr_pkg::*;
#(
  parameter int LUT_AW = 12,
  parameter int NCO_W  = SDR_NCO_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LUT_AW-1:0]       phase,
  output logic signed [NCO_W-1:0] cos_o,
  output logic signed [NCO_W-1:0] sin_o
);

  localparam int QAW = LUT_AW - 2;
  localparam int QN  = 1 << QAW;
  localparam int AMP = (1 << (NCO_W - 1)) - 1;

  // QN+1 entries so that 90 degrees (index QN) is stored exactly as full scale
  logic signed [NCO_W-1:0] rom [QN+1];

  for (genvar gi = 0; gi <= QN; gi++) begin : g_rom
    localparam logic signed [NCO_W-1:0] ENTRY = NCO_W'(quarter_sine(gi, QN, AMP));
    assign rom[gi] = ENTRY;
  end

  logic [1:0]              quad;
  logic [QAW:0]            idx_fwd;
  logic [QAW:0]            idx_rev;
  logic signed [NCO_W-1:0] sin_mag;
  logic signed [NCO_W-1:0] cos_mag;
  logic signed [NCO_W-1:0] cos_d, cos_q;
  logic signed [NCO_W-1:0] sin_d, sin_q;

  // Quadrant folding:
  //   q0: sin= T[i]      cos= T[QN-i]
  //   q1: sin= T[QN-i]   cos=-T[i]
  //   q2: sin=-T[i]      cos=-T[QN-i]
  //   q3: sin=-T[QN-i]   cos= T[i]
  // Table values never exceed AMP, so negation never produces the most
  // negative code.
  always_comb begin
    quad    = phase[LUT_AW-1 -: 2];
    idx_fwd = {1'b0, phase[QAW-1:0]};
    idx_rev = (QAW+1)'(QN) - idx_fwd;
    sin_mag = quad[0] ? rom[idx_rev] : rom[idx_fwd];
    cos_mag = quad[0] ? rom[idx_fwd] : rom[idx_rev];
    sin_d   = quad[1] ? -sin_mag : sin_mag;
    cos_d   = (quad[0] ^ quad[1]) ? -cos_mag : cos_mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cos_q <= '0;
      sin_q <= '0;
    end else begin
      cos_q <= cos_d;
      sin_q <= sin_d;
    end
  end

  assign cos_o = cos_q;
  assign sin_o = sin_q;

endmodule

// File: rtl/sdr_core.sv
// sdr_core: four-lane digital down-converter. Accepts one 4-sample frame per
// cycle (two samples each from interleaved ADCs A and B), mixes every sample
// with a phase-continuous complex NCO and outputs four I/Q product pairs.
//   sysclk          : system clock
//   rst_i           : asynchronous active-low reset
//   wr_en_fifo_a/b  : frame valid from ADC A / B; a frame is taken only when both are 1
//   data_a/data_b   : two signed 12-bit samples each, [11:0] rising, [23:12] falling
//   out_valid       : inphase/quadrature hold a new frame (3 cycles after acceptance)
//   inphase0..3     : x*cos(phi), lanes 0..3, 28-bit signed
//   quadrature0..3  : -x*sin(phi), lanes 0..3, 28-bit signed
module sdr_core
  import sdr_pkg::*;
#(
  parameter int                 PHASE_W = 32,
  parameter logic [PHASE_W-1:0] FTW     = PHASE_W'(SDR_FTW_DEFAULT),
  parameter int                 LUT_AW  = 12,
  parameter int                 NCO_W   = SDR_NCO_W
) (
  input  logic                    sysclk,
  input  logic                    rst_i,
  input  logic                    wr_en_fifo_a,
  input  logic                    wr_en_fifo_b,
  input  logic [2*SDR_ADC_W-1:0]  data_a,
  input  logic [2*SDR_ADC_W-1:0]  data_b,
  output logic                    out_valid,
  output logic [SDR_PROD_W-1:0]   inphase0,
  output logic [SDR_PROD_W-1:0]   inphase1,
  output logic [SDR_PROD_W-1:0]   inphase2,
  output logic [SDR_PROD_W-1:0]   inphase3,
  output logic [SDR_PROD_W-1:0]   quadrature0,
  output logic [SDR_PROD_W-1:0]   quadrature1,
  output logic [SDR_PROD_W-1:0]   quadrature2,
  output logic [SDR_PROD_W-1:0]   quadrature3
);

  // Accumulator advances by one frame = 4 samples; wraps modulo 2^PHASE_W.
  localparam logic [PHASE_W-1:0] FTW4 = FTW << 2;

  logic                    accept;
  logic [PHASE_W-1:0]      acc_d, acc_q;
  logic                    v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
  sample_t                 lane_x  [SDR_LANES];
  logic [PHASE_W-1:0]      lane_ph [SDR_LANES];
  sample_t                 s1_d [SDR_LANES], s1_q [SDR_LANES];
  sample_t                 s2_d [SDR_LANES], s2_q [SDR_LANES];
  logic [LUT_AW-1:0]       ph1_d [SDR_LANES], ph1_q [SDR_LANES];
  logic signed [NCO_W-1:0] cos_w [SDR_LANES];
  logic signed [NCO_W-1:0] sin_w [SDR_LANES];
  iq_t                     iq_d [SDR_LANES], iq_q [SDR_LANES];
  logic                    unused_ph_lsb;

  always_comb begin
    accept = wr_en_fifo_a & wr_en_fifo_b;

    // Time order across the two interleaved ADCs: A rise, B rise, A fall, B fall
    lane_x[0] = data_a[SDR_ADC_W-1:0];
    lane_x[1] = data_b[SDR_ADC_W-1:0];
    lane_x[2] = data_a[2*SDR_ADC_W-1:SDR_ADC_W];
    lane_x[3] = data_b[2*SDR_ADC_W-1:SDR_ADC_W];

    unused_ph_lsb = 1'b0;
    for (int k = 0; k < SDR_LANES; k++) begin
      lane_ph[k] = acc_q + PHASE_W'(k) * FTW;
      // Phase bits below the LUT resolution are dropped (phase truncation)
      unused_ph_lsb = unused_ph_lsb ^ (^lane_ph[k][PHASE_W-LUT_AW-1:0]);
    end

    acc_d = accept ? acc_q + FTW4 : acc_q;
    v1_d  = accept;
    v2_d  = v1_q;
    v3_d  = v2_q;

    for (int k = 0; k < SDR_LANES; k++) begin
      s1_d[k]  = accept ? lane_x[k] : s1_q[k];
      ph1_d[k] = accept ? lane_ph[k][PHASE_W-1 -: LUT_AW] : ph1_q[k];
      // s2 lines up with the LUT output register
      s2_d[k]  = v1_q ? s1_q[k] : s2_q[k];
      iq_d[k]  = iq_q[k];
      if (v2_q) begin
        iq_d[k].i = SDR_PROD_W'(s2_q[k]) * SDR_PROD_W'(cos_w[k]);
        iq_d[k].q = -(SDR_PROD_W'(s2_q[k]) * SDR_PROD_W'(sin_w[k]));
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_i) begin
    if (!rst_i) begin
      acc_q <= '0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      for (int k = 0; k < SDR_LANES; k++) begin
        s1_q[k]  <= '0;
        s2_q[k]  <= '0;
        ph1_q[k] <= '0;
        iq_q[k]  <= '0;
      end
    end else begin
      acc_q <= acc_d;
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      for (int k = 0; k < SDR_LANES; k++) begin
        s1_q[k]  <= s1_d[k];
        s2_q[k]  <= s2_d[k];
        ph1_q[k] <= ph1_d[k];
        iq_q[k]  <= iq_d[k];
      end
    end
  end

  for (genvar gi = 0; gi < SDR_LANES; gi++) begin : g_lane
    nco_lut #(
      .LUT_AW(LUT_AW),
      .NCO_W (NCO_W)
    ) u_lut (
      .clk  (sysclk),
      .rst_n(rst_i),
      .phase(ph1_q[gi]),
      .cos_o(cos_w[gi]),
      .sin_o(sin_w[gi])
    );
  end

  assign out_valid   = v3_q;
  assign inphase0    = iq_q[0].i;
  assign inphase1    = iq_q[1].i;
  assign inphase2    = iq_q[2].i;
  assign inphase3    = iq_q[3].i;
  assign quadrature0 = iq_q[0].q;
  assign quadrature1 = iq_q[1].q;
  assign quadrature2 = iq_q[2].q;
  assign quadrature3 = iq_q[3].q;

endmodule

// File: tb/tb_sdr_core.sv
// tb_sdr_core: directed bench for sdr_core. Three instances share the same
// stimulus with different tuning words: FTW=0 (DC), FTW=2^30 (Fs/4) and the
// default 200 MHz word. Expected values are hand-computed constants.
module tb_sdr_core;

  logic        sysclk = 1'b0;
  logic        rst_i;
  logic        en_a, en_b;
  logic [23:0] data_a, data_b;

  logic        dc_v, fs4_v, def_v;
  logic [27:0] dc_i [4], dc_q [4];
  logic [27:0] fs4_i [4], fs4_q [4];
  logic [27:0] def_i [4], def_q [4];

  int n_cmp = 0;
  int n_bad = 0;

  localparam longint FS = 32767;

  always #2 sysclk = ~sysclk;

  sdr_core #(.FTW(32'd0)) u_dc (
    .sysclk(sysclk), .rst_i(rst_i), .wr_en_fifo_a(en_a), .wr_en_fifo_b(en_b),
    .data_a(data_a), .data_b(data_b), .out_valid(dc_v),
    .inphase0(dc_i[0]), .inphase1(dc_i[1]), .inphase2(dc_i[2]), .inphase3(dc_i[3]),
    .quadrature0(dc_q[0]), .quadrature1(dc_q[1]), .quadrature2(dc_q[2]), .quadrature3(dc_q[3])
  );

  sdr_core #(.FTW(32'h4000_0000)) u_fs4 (
    .sysclk(sysclk), .rst_i(rst_i), .wr_en_fifo_a(en_a), .wr_en_fifo_b(en_b),
    .data_a(data_a), .data_b(data_b), .out_valid(fs4_v),
    .inphase0(fs4_i[0]), .inphase1(fs4_i[1]), .inphase2(fs4_i[2]), .inphase3(fs4_i[3]),
    .quadrature0(fs4_q[0]), .quadrature1(fs4_q[1]), .quadrature2(fs4_q[2]), .quadrature3(fs4_q[3])
  );

  sdr_core u_def (
    .sysclk(sysclk), .rst_i(rst_i), .wr_en_fifo_a(en_a), .wr_en_fifo_b(en_b),
    .data_a(data_a), .data_b(data_b), .out_valid(def_v),
    .inphase0(def_i[0]), .inphase1(def_i[1]), .inphase2(def_i[2]), .inphase3(def_i[3]),
    .quadrature0(def_q[0]), .quadrature1(def_q[1]), .quadrature2(def_q[2]), .quadrature3(def_q[3])
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  function automatic longint s28(input logic [27:0] v);
    return longint'($signed(v));
  endfunction

  function automatic logic [23:0] pk(input int x);
    logic [11:0] s;
    s = 12'(x);
    return {s, s};
  endfunction

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic set_all(input int x);
    data_a = pk(x);
    data_b = pk(x);
  endtask

  // Fs/4: lane phases 0/90/180/270 deg every frame
  task automatic chk_fs4(input string tag, input longint x);
    longint ci [4];
    longint si [4];
    ci = '{1, 0, -1, 0};
    si = '{0, 1, 0, -1};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_i%0d", tag, k), s28(fs4_i[k]), x * FS * ci[k]);
      chk($sformatf("%s_q%0d", tag, k), s28(fs4_q[k]), -x * FS * si[k]);
    end
  endtask

  task automatic chk_dc(input string tag, input longint x);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_i%0d", tag, k), s28(dc_i[k]), x * FS);
      chk($sformatf("%s_q%0d", tag, k), s28(dc_q[k]), 0);
    end
  endtask

  initial begin
    logic exp_v [10];

    // Reset held with random data and both enables high
    rst_i  = 1'b0;
    en_a   = 1'b1;
    en_b   = 1'b1;
    data_a = 24'($urandom);
    data_b = 24'($urandom);
    for (int c = 0; c < 4; c++) begin
      tick();
      data_a = 24'($urandom);
      data_b = 24'($urandom);
      chk("rst_dc_valid", dc_v, 0);
      chk("rst_def_valid", def_v, 0);
      chk("rst_def_i0", s28(def_i[0]), 0);
      chk("rst_fs4_q3", s28(fs4_q[3]), 0);
    end

    // Release with data already valid: first cycle is a normal acceptance
    rst_i = 1'b1;
    set_all(1000);
    tick(); chk("lat_valid_c1", dc_v, 0);
    tick(); chk("lat_valid_c2", dc_v, 0);
    tick(); chk("lat_valid_c3", dc_v, 1);
    chk_dc("dc1000", 1000);
    chk_fs4("fs4_f0", 1000);
    chk("def_f0_i0", s28(def_i[0]), 1000 * FS);
    chk("def_f0_q0", s28(def_q[0]), 0);
    tick();
    chk("b2b_valid", fs4_v, 1);
    chk_fs4("fs4_f1", 1000);

    // Extremes
    set_all(-2048);
    repeat (3) tick();
    chk_dc("dc_m2048", -2048);
    chk_fs4("fs4_m2048", -2048);
    set_all(2047);
    repeat (3) tick();
    chk_dc("dc_p2047", 2047);
    chk_fs4("fs4_p2047", 2047);

    // Mid-run reset: outputs clear asynchronously, in-flight frames discarded
    set_all(1000);
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    chk("async_def_valid", def_v, 0);
    chk("async_dc_i0", s28(dc_i[0]), 0);
    chk("async_fs4_q1", s28(fs4_q[1]), 0);
    tick();
    rst_i = 1'b1;

    // After release: B gated low for two edges; the accumulator must hold,
    // so the sixth accepted frame has lane0 phase 20*FTW = -4 (mod 2^32):
    // quadrant 3, index 1023 -> cos = T[1023] = 32767, sin = -T[1] = -50.
    exp_v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk($sformatf("gate_valid_e%0d", e), def_v, exp_v[e-1]);
      chk($sformatf("gate_fs4_valid_e%0d", e), fs4_v, exp_v[e-1]);
      if (e == 2) en_b = 1'b0;
      if (e == 4) en_b = 1'b1;
      if (e == 3) begin
        chk("restart_def_q0", s28(def_q[0]), 0);
        chk("restart_def_i0", s28(def_i[0]), 1000 * FS);
      end
      if (e == 5) begin
        chk("gap_hold_fs4_i0", s28(fs4_i[0]), 1000 * FS);
        chk("gap_hold_fs4_q1", s28(fs4_q[1]), -1000 * FS);
      end
      if (e == 10) begin
        chk("f5_def_i0", s28(def_i[0]), 1000 * FS);
        chk("f5_def_q0", s28(def_q[0]), 50000);
        chk_fs4("fs4_after_gap", 1000);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
